// File: rtl/sprite_line_engine.sv
// Double-buffered sprite scanline engine: scans the attribute table for the next
// line into the back bank while the front bank resolves per-pixel palette indices.
module sprite_line_engine #(
    parameter int MAX_SPRITES  = 8,
    parameter int SPRITE_ATTRS = 64,
    parameter int SPRITE_W     = 16,
    parameter int SPRITE_H     = 16,
    parameter int BPP          = 2
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            line_start,
    input  logic [9:0]                      next_line,
    output logic [$clog2(SPRITE_ATTRS)-1:0] attr_addr,
    input  logic [31:0]                     attr_data,
    output logic [11:0]                     pix_addr,
    input  logic [SPRITE_W*BPP-1:0]         pix_data,
    input  logic [9:0]                      pixel_x,
    input  logic                            pixel_valid,
    output logic [2+BPP:0]                  pixel_out,
    output logic                            pixel_opaque,
    output logic                            overflow,
    output logic                            busy
);
    localparam int AW = $clog2(SPRITE_ATTRS);
    localparam int SW = (MAX_SPRITES > 1) ? $clog2(MAX_SPRITES) : 1;
    localparam int VW = $clog2(MAX_SPRITES + 1);
    localparam int OW = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
    localparam int RW = SPRITE_W * BPP;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_A_REQ  = 3'd1;
    localparam logic [2:0] S_A_CHK  = 3'd2;
    localparam logic [2:0] S_P_LOAD = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    localparam logic [AW-1:0] AC_LAST = AW'(SPRITE_ATTRS - 1);
    localparam logic [VW-1:0] VC_FULL = VW'(MAX_SPRITES);
    localparam logic [10:0]   H_L     = 11'(SPRITE_H);
    localparam logic [10:0]   W_L     = 11'(SPRITE_W);

    logic [2:0]    state;
    logic [AW-1:0] ac;
    logic [VW-1:0] vc;
    logic [9:0]    line_y;
    logic [9:0]    ld_x;
    logic [2:0]    ld_pal;
    logic          ld_hflip;
    logic [11:0]   pix_addr_q;
    logic          back_ovf;
    logic          front;
    logic          back;

    logic [MAX_SPRITES-1:0] slot_valid [2];
    logic [9:0]             slot_x     [2][MAX_SPRITES];
    logic [2:0]             slot_pal   [2][MAX_SPRITES];
    logic [RW-1:0]          slot_row   [2][MAX_SPRITES];

    logic [9:0]    a_y;
    logic [10:0]   a_row;
    logic          visible;
    logic          load_now;
    logic [11:0]   pa_c;
    logic [RW-1:0] row_in;

    assign back      = ~front;
    assign attr_addr = ac;
    assign a_y       = attr_data[9:0];
    // Eleven-bit difference so a sprite starting below the line never wraps into range.
    assign a_row     = {1'b0, line_y} - {1'b0, a_y};
    assign visible   = (line_y >= a_y) && (a_row < H_L);
    assign load_now  = (state == S_A_CHK) && visible && (vc < VC_FULL);
    assign pa_c      = 12'(32'(attr_data[27:20]) * 32'(SPRITE_H) + 32'(a_row));
    assign pix_addr  = load_now ? pa_c : pix_addr_q;

    // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        row_in = pix_data;
        if (ld_hflip) begin
            for (int i = 0; i < SPRITE_W; i++)
                row_in[i*BPP +: BPP] = pix_data[(SPRITE_W-1-i)*BPP +: BPP];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= S_IDLE;
            ac            <= '0;
            vc            <= '0;
            line_y        <= '0;
            ld_x          <= '0;
            ld_pal        <= '0;
            ld_hflip      <= 1'b0;
            pix_addr_q    <= '0;
            back_ovf      <= 1'b0;
            overflow      <= 1'b0;
            busy          <= 1'b0;
            front         <= 1'b0;
            slot_valid[0] <= '0;
            slot_valid[1] <= '0;
        end else if (line_start) begin
            // An unfinished scan still goes live, but is flagged as having lost sprites.
            front             <= back;
            overflow          <= (state == S_IDLE || state == S_DONE) ? back_ovf : 1'b1;
            back_ovf          <= 1'b0;
            slot_valid[front] <= '0;
            line_y            <= next_line;
            ac                <= '0;
            vc                <= '0;
            busy              <= 1'b1;
            state             <= S_A_REQ;
        end else begin
            case (state)
                S_A_REQ: state <= S_A_CHK;
                S_A_CHK: begin
                    if (visible) begin
                        if (vc < VC_FULL) begin
                            ld_x       <= attr_data[19:10];
                            ld_pal     <= attr_data[30:28];
                            ld_hflip   <= attr_data[31];
                            pix_addr_q <= pa_c;
                            state      <= S_P_LOAD;
                        end else begin
                            back_ovf <= 1'b1;
                            busy     <= 1'b0;
                            state    <= S_DONE;
                        end
                    end else if (ac == AC_LAST) begin
                        busy  <= 1'b0;
                        state <= S_DONE;
                    end else begin
                        ac    <= ac + 1'b1;
                        state <= S_A_REQ;
                    end
                end
                S_P_LOAD: begin
                    slot_valid[back][vc[SW-1:0]] <= 1'b1;
                    vc <= vc + 1'b1;
                    if (ac == AC_LAST) begin
                        busy  <= 1'b0;
                        state <= S_DONE;
                    end else begin
                        ac    <= ac + 1'b1;
                        state <= S_A_REQ;
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: slot payload is always qualified by slot_valid, so it is plain storage with no reset.
    always_ff @(posedge clk) begin
        if (!line_start && state == S_P_LOAD) begin
            slot_x[back][vc[SW-1:0]]   <= ld_x;
            slot_pal[back][vc[SW-1:0]] <= ld_pal;
            slot_row[back][vc[SW-1:0]] <= row_in;
        end
    end

    logic [9:0]     lk_off;
    logic [BPP-1:0] lk_pix;
    logic           lk_hit;
    logic [2+BPP:0] lk_val;

    // Walk from the highest slot down so the lowest-index hit is the one left standing.
    always_comb begin
        lk_hit = 1'b0;
        lk_val = '0;
        lk_off = '0;
        lk_pix = '0;
        for (int s = MAX_SPRITES - 1; s >= 0; s--) begin
            lk_off = pixel_x - slot_x[front][s];
            lk_pix = slot_row[front][s][lk_off[OW-1:0]*BPP +: BPP];
            if (slot_valid[front][s] && (pixel_x >= slot_x[front][s]) &&
                ({1'b0, lk_off} < W_L) && (lk_pix != '0)) begin
                lk_hit = 1'b1;
                lk_val = {slot_pal[front][s], lk_pix};
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pixel_out    <= '0;
            pixel_opaque <= 1'b0;
        end else begin
            pixel_opaque <= pixel_valid && lk_hit;
            pixel_out    <= (pixel_valid && lk_hit) ? lk_val : '0;
        end
    end

endmodule
